serpario_chain_ctrl: RTL and testbench

Parametrised controller for daisy-chained shift-register I/O expanders (595-style output chain, 165-style input chain) on the mico32 platform boards. It is the next generation of the platform's serial/parallel I/O port: generic chain widths, programmable shift-clock rate, separate parallel-load strobe for the input chain, auto-refresh mode and gated output enable. It sits between the Wishbone register slave (driver side) and the board pins `SER_OUT`, `SER_IN`, `SH_CLK`, `STORE`, `OUT_EN`.

---
 rtl/serpario_chain_ctrl_pkg.sv | 26 ++
 rtl/serpario_chain_ctrl_tick.sv | 30 +++
 rtl/serpario_chain_ctrl.sv | 132 +++++++++++++
 tb/tb_serpario_chain_ctrl.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serpario_chain_ctrl_pkg.sv
// Shared types and helpers for the serial/parallel
// shift-register chain controller.
package serpario_chain_ctrl_pkg;

  typedef enum logic [2:0] {
    SP_IDLE,
    SP_LOAD,
    SP_SHIFT,
    SP_STORE,
    SP_DONE
  } spState_t;

  function automatic int spClog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int spMax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/serpario_chain_ctrl_tick.sv
// Shift-clock phase divider: one tick every DIV
// cycles, restarted by clr.
module serpario_chain_ctrl_tick
  import serpario_chain_ctrl_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = spMax(1, spClog2(DIV));

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/serpario_chain_ctrl.sv
// Frame controller for 595-style output and
// 165-style input daisy chains.
module serpario_chain_ctrl
  import serpario_chain_ctrl_pkg::*;
#(
  parameter int OUT_BITS = 16,
  parameter int IN_BITS  = 16,
  parameter int CLK_DIV  = 4
) (
  input  logic                clk_i,
  input  logic                reset,
  input  logic                start_i,
  input  logic                auto_en_i,
  input  logic                oe_en_i,
  input  logic [OUT_BITS-1:0] out_data_i,
  output logic [IN_BITS-1:0]  in_data_o,
  output logic                busy_o,
  output logic                done_o,
  input  logic                ser_in_i,
  output logic                ser_out_o,
  output logic                sh_clk_o,
  output logic                store_o,
  output logic                ld_n_o,
  output logic                out_en_o
);

  localparam int N  = spMax(OUT_BITS, IN_BITS);
  localparam int CW = spClog2(N + 1);

  spState_t      state;
  logic          highPh;
  logic [CW-1:0] bitCnt;
  logic [N-1:0]  outSr;
  logic [N-1:0]  inSr;
  logic          stored;
  logic          tick;
  logic          tickClr;
  logic          startFrame;

  // IDLE and DONE both precede a LOAD entry, so
  // holding the divider there restarts its phase.
  assign tickClr = (state == SP_IDLE) ||
                   (state == SP_DONE);

  assign startFrame = auto_en_i ||
                      (start_i && state == SP_IDLE);

  serpario_chain_ctrl_tick #(
    .DIV (CLK_DIV)
  ) uTick (
    .clk  (clk_i),
    .rst  (reset),
    .clr  (tickClr),
    .tick (tick)
  );

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state     <= SP_IDLE;
      highPh    <= 1'b0;
      bitCnt    <= '0;
      outSr     <= '0;
      inSr      <= '0;
      stored    <= 1'b0;
      in_data_o <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      ser_out_o <= 1'b0;
      sh_clk_o  <= 1'b0;
      store_o   <= 1'b0;
      ld_n_o    <= 1'b1;
      out_en_o  <= 1'b0;
    end else begin
      out_en_o <= oe_en_i & stored;
      done_o   <= 1'b0;
      unique case (state)
        SP_IDLE, SP_DONE: begin
          if (startFrame) begin
            state  <= SP_LOAD;
            busy_o <= 1'b1;
            ld_n_o <= 1'b0;
            outSr  <= N'(out_data_i);
          end else begin
            state <= SP_IDLE;
          end
        end
        SP_LOAD: begin
          if (tick) begin
            state     <= SP_SHIFT;
            ld_n_o    <= 1'b1;
            highPh    <= 1'b0;
            bitCnt    <= CW'(N);
            ser_out_o <= outSr[N-1];
            outSr     <= outSr << 1;
          end
        end
        SP_SHIFT: begin
          if (tick && !highPh) begin
            // last cycle of the low phase
            highPh   <= 1'b1;
            sh_clk_o <= 1'b1;
            inSr     <= inSr << 1;
            inSr[0]  <= ser_in_i;
          end else if (tick) begin
            highPh   <= 1'b0;
            sh_clk_o <= 1'b0;
            bitCnt   <= bitCnt - CW'(1);
            if (bitCnt == CW'(1)) begin
              state   <= SP_STORE;
              store_o <= 1'b1;
            end else begin
              ser_out_o <= outSr[N-1];
              outSr     <= outSr << 1;
            end
          end
        end
        SP_STORE: begin
          if (tick) begin
            state     <= SP_DONE;
            store_o   <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
            stored    <= 1'b1;
            in_data_o <= inSr[N-1 -: IN_BITS];
          end
        end
        default: state <= SP_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serpario_chain_ctrl.sv
// Directed bench: loopback, chain models, auto
// refresh, output enable and mid-frame reset.
module tb_serpario_chain_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nRun = 0;
  int nFail = 0;

  // A: 8/8, div 2, loopback
  logic       rstA, startA, autoA, oeA;
  logic [7:0] dataA, inA;
  logic       busyA, doneA, serInA, serOutA;
  logic       shA, storeA, ldA, oeOutA;
  assign serInA = serOutA;

  serpario_chain_ctrl #(
    .OUT_BITS(8), .IN_BITS(8), .CLK_DIV(2)
  ) dutA (
    .clk_i(clk), .reset(rstA),
    .start_i(startA), .auto_en_i(autoA),
    .oe_en_i(oeA), .out_data_i(dataA),
    .in_data_o(inA), .busy_o(busyA),
    .done_o(doneA), .ser_in_i(serInA),
    .ser_out_o(serOutA), .sh_clk_o(shA),
    .store_o(storeA), .ld_n_o(ldA),
    .out_en_o(oeOutA)
  );

  // B: 16 out / 8 in, div 2, chain models
  logic        rstBC, startB, autoB, oeB;
  logic [15:0] dataB;
  logic [7:0]  inB;
  logic        busyB, doneB, serInB, serOutB;
  logic        shB, storeB, ldB, oeOutB;
  logic [15:0] sr595, latch595;
  logic [7:0]  r165;
  int          shCountB = 0;
  assign serInB = r165[7];

  always @(posedge shB) begin
    sr595    <= {sr595[14:0], serOutB};
    shCountB <= shCountB + 1;
  end
  always @(posedge storeB) latch595 <= sr595;
  always @(negedge ldB or posedge shB) begin
    if (!ldB) r165 <= 8'h3C;
    else      r165 <= {r165[6:0], 1'b0};
  end

  serpario_chain_ctrl #(
    .OUT_BITS(16), .IN_BITS(8), .CLK_DIV(2)
  ) dutB (
    .clk_i(clk), .reset(rstBC),
    .start_i(startB), .auto_en_i(autoB),
    .oe_en_i(oeB), .out_data_i(dataB),
    .in_data_o(inB), .busy_o(busyB),
    .done_o(doneB), .ser_in_i(serInB),
    .ser_out_o(serOutB), .sh_clk_o(shB),
    .store_o(storeB), .ld_n_o(ldB),
    .out_en_o(oeOutB)
  );

  // C: 8/8, div 1, loopback, auto refresh
  logic       startC, autoC, oeC;
  logic [7:0] dataC, inC;
  logic       busyC, doneC, serInC, serOutC;
  logic       shC, storeC, ldC, oeOutC;
  assign serInC = serOutC;

  serpario_chain_ctrl #(
    .OUT_BITS(8), .IN_BITS(8), .CLK_DIV(1)
  ) dutC (
    .clk_i(clk), .reset(rstBC),
    .start_i(startC), .auto_en_i(autoC),
    .oe_en_i(oeC), .out_data_i(dataC),
    .in_data_o(inC), .busy_o(busyC),
    .done_o(doneC), .ser_in_i(serInC),
    .ser_out_o(serOutC), .sh_clk_o(shC),
    .store_o(storeC), .ld_n_o(ldC),
    .out_en_o(oeOutC)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic test_reset;
    logic [6:0] pins;
    rstA = 1; rstBC = 1;
    startA = 0; autoA = 0; oeA = 1; dataA = 0;
    startB = 0; autoB = 0; oeB = 0; dataB = 0;
    startC = 0; autoC = 0; oeC = 0; dataC = 0;
    repeat (3) @(negedge clk);
    pins = {serOutA, shA, storeA, oeOutA,
            busyA, doneA, ldA};
    nRun++;
    if (pins !== 7'b0000001) begin
      nFail++;
      $display("FAIL reset_pins got %b want 0000001",
               pins);
    end
    nRun++;
    if (inA !== 8'h00) begin
      nFail++;
      $display("FAIL reset_in_data got %h want 00",
               inA);
    end
    rstA = 0; rstBC = 0;
    @(negedge clk);
    nRun++;
    if ({ldB, busyB, ldC, busyC} !== 4'b1010) begin
      nFail++;
      $display("FAIL reset_idle got %b want 1010",
               {ldB, busyB, ldC, busyC});
    end
  endtask

  task automatic test_loopback;
    int busyCnt = 0, shRise = 0;
    int storeCnt = 0, storePulses = 0;
    logic [7:0] bits = 0, inAtDone = 0;
    logic prevSh = 0, prevStore = 0;
    logic gotDone = 0, busyAtDone = 1;
    logic oeEarly = 0;
    dataA = 8'hA5;
    startA = 1;
    @(negedge clk);
    startA = 0;
    for (int c = 0; c < 200 && !gotDone; c++) begin
      busyCnt += int'(busyA);
      if (shA && !prevSh) begin
        shRise++;
        bits = {bits[6:0], serOutA};
      end
      prevSh = shA;
      if (storeA) storeCnt++;
      if (storeA && !prevStore) storePulses++;
      prevStore = storeA;
      if (oeOutA) oeEarly = 1;
      if (doneA) begin
        gotDone = 1;
        inAtDone = inA;
        busyAtDone = busyA;
      end else begin
        @(negedge clk);
      end
    end
    nRun++;
    if (!gotDone) begin
      nFail++;
      $display("FAIL loop_done got none want pulse");
    end
    nRun++;
    if (busyCnt != 36) begin
      nFail++;
      $display("FAIL loop_busy got %0d want 36",
               busyCnt);
    end
    nRun++;
    if (shRise != 8) begin
      nFail++;
      $display("FAIL loop_shclk got %0d want 8",
               shRise);
    end
    nRun++;
    if (bits !== 8'hA5) begin
      nFail++;
      $display("FAIL loop_serout got %h want a5",
               bits);
    end
    nRun++;
    if (storeCnt != 2 || storePulses != 1) begin
      nFail++;
      $display("FAIL loop_store got %0d/%0d want 2/1",
               storeCnt, storePulses);
    end
    nRun++;
    if (inAtDone !== 8'hA5 || busyAtDone !== 1'b0)
    begin
      nFail++;
      $display("FAIL loop_in got %h/%b want a5/0",
               inAtDone, busyAtDone);
    end
    nRun++;
    if (oeEarly !== 1'b0) begin
      nFail++;
      $display("FAIL loop_oe_early got 1 want 0");
    end
  endtask

  task automatic test_output_enable;
    @(negedge clk);
    nRun++;
    if (oeOutA !== 1'b1) begin
      nFail++;
      $display("FAIL oe_rise got %b want 1", oeOutA);
    end
    oeA = 0;
    @(negedge clk);
    nRun++;
    if (oeOutA !== 1'b0) begin
      nFail++;
      $display("FAIL oe_fall got %b want 0", oeOutA);
    end
  endtask

  task automatic test_start_held;
    int doneRise = 0, doneHigh = 0;
    int busyRise = 0, firstDone = -1;
    logic prevBusy = 0, prevDone = 0;
    logic ended = 0;
    dataA = 8'h5A;
    startA = 1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (busyA && !prevBusy) busyRise++;
      prevBusy = busyA;
      if (doneA) doneHigh++;
      if (doneA && !prevDone) begin
        doneRise++;
        if (firstDone < 0) firstDone = c;
      end
      prevDone = doneA;
    end
    startA = 0;
    for (int c = 0; c < 100 && !ended; c++) begin
      @(negedge clk);
      if (doneA) ended = 1;
    end
    @(negedge clk);
    nRun++;
    if (doneRise != 2 || doneHigh != 2) begin
      nFail++;
      $display("FAIL held_done got %0d/%0d want 2/2",
               doneRise, doneHigh);
    end
    nRun++;
    if (busyRise != 3 || firstDone != 37) begin
      nFail++;
      $display("FAIL held_frames got %0d/%0d want 3/37",
               busyRise, firstDone);
    end
    nRun++;
    if (!ended || busyA !== 1'b0) begin
      nFail++;
      $display("FAIL held_end got %b/%b want 1/0",
               ended, busyA);
    end
  endtask

  task automatic test_reset_mid_shift;
    int shRise = 0, busyCnt = 0;
    logic prevSh = 0, storeSeen = 0;
    logic busySeen = 0, gotDone = 0;
    logic oeAtDone = 1;
    logic [7:0] inAtDone = 0;
    logic [6:0] pins;
    dataA = 8'hFF;
    oeA = 1;
    startA = 1;
    @(negedge clk);
    startA = 0;
    for (int c = 0; c < 100 && shRise < 3; c++) begin
      if (shA && !prevSh) shRise++;
      prevSh = shA;
      if (shRise < 3) @(negedge clk);
    end
    nRun++;
    if (oeOutA !== 1'b1 || busyA !== 1'b1) begin
      nFail++;
      $display("FAIL mid_pre got %b%b want 11",
               oeOutA, busyA);
    end
    #2 rstA = 1;
    #1;
    pins = {serOutA, shA, storeA, oeOutA,
            busyA, doneA, ldA};
    nRun++;
    if (pins !== 7'b0000001 || inA !== 8'h00) begin
      nFail++;
      $display("FAIL mid_reset got %b/%h want 0000001/00",
               pins, inA);
    end
    repeat (2) @(negedge clk);
    rstA = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (storeA) storeSeen = 1;
      if (busyA) busySeen = 1;
    end
    nRun++;
    if (storeSeen || busySeen) begin
      nFail++;
      $display("FAIL mid_quiet got %b%b want 00",
               storeSeen, busySeen);
    end
    dataA = 8'h3C;
    startA = 1;
    @(negedge clk);
    startA = 0;
    for (int c = 0; c < 200 && !gotDone; c++) begin
      busyCnt += int'(busyA);
      if (doneA) begin
        gotDone = 1;
        inAtDone = inA;
        oeAtDone = oeOutA;
      end else begin
        @(negedge clk);
      end
    end
    nRun++;
    if (!gotDone || inAtDone !== 8'h3C ||
        busyCnt != 36) begin
      nFail++;
      $display("FAIL mid_after got %b/%h/%0d want 1/3c/36",
               gotDone, inAtDone, busyCnt);
    end
    nRun++;
    if (oeAtDone !== 1'b0) begin
      nFail++;
      $display("FAIL mid_oe got %b want 0", oeAtDone);
    end
    @(negedge clk);
    nRun++;
    if (oeOutA !== 1'b1) begin
      nFail++;
      $display("FAIL mid_oe_rise got %b want 1",
               oeOutA);
    end
  endtask

  task automatic test_chain;
    int base, busyCnt = 0;
    logic gotDone = 0;
    logic [7:0] inAtDone = 0;
    base = shCountB;
    dataB = 16'h1234;
    startB = 1;
    @(negedge clk);
    startB = 0;
    for (int c = 0; c < 300 && !gotDone; c++) begin
      busyCnt += int'(busyB);
      if (doneB) begin
        gotDone = 1;
        inAtDone = inB;
      end else begin
        @(negedge clk);
      end
    end
    nRun++;
    if (latch595 !== 16'h1234) begin
      nFail++;
      $display("FAIL chain_595 got %h want 1234",
               latch595);
    end
    nRun++;
    if (!gotDone || inAtDone !== 8'h3C) begin
      nFail++;
      $display("FAIL chain_165 got %b/%h want 1/3c",
               gotDone, inAtDone);
    end
    nRun++;
    if (shCountB - base != 16 || busyCnt != 68) begin
      nFail++;
      $display("FAIL chain_clk got %0d/%0d want 16/68",
               shCountB - base, busyCnt);
    end
  endtask

  task automatic test_auto;
    int dones = 0, d1 = -1, d2 = -1;
    logic [7:0] in1 = 8'h55, in2 = 8'h55;
    logic ldAfter = 1, busyAfter = 0;
    dataC = 8'h00;
    autoC = 1;
    for (int c = 1; c <= 60 && dones < 2; c++) begin
      @(negedge clk);
      if (c == 5) dataC = 8'hFF;
      if (dones == 1 && c == d1 + 1) begin
        ldAfter = ldC;
        busyAfter = busyC;
      end
      if (doneC) begin
        dones++;
        if (dones == 1) begin
          d1 = c;
          in1 = inC;
        end else begin
          d2 = c;
          in2 = inC;
        end
      end
    end
    autoC = 0;
    @(negedge clk);
    nRun++;
    if (d1 != 19 || d2 != 38) begin
      nFail++;
      $display("FAIL auto_period got %0d/%0d want 19/38",
               d1, d2);
    end
    nRun++;
    if (ldAfter !== 1'b0 || busyAfter !== 1'b1) begin
      nFail++;
      $display("FAIL auto_reload got %b%b want 01",
               ldAfter, busyAfter);
    end
    nRun++;
    if (in1 !== 8'h00 || in2 !== 8'hFF) begin
      nFail++;
      $display("FAIL auto_data got %h/%h want 00/ff",
               in1, in2);
    end
    nRun++;
    if (busyC !== 1'b0) begin
      nFail++;
      $display("FAIL auto_stop got %b want 0", busyC);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_output_enable();
    test_start_held();
    test_reset_mid_shift();
    test_chain();
    test_auto();
    $display("[TB] %0d tests run, %0d failed",
             nRun, nFail);
    $finish;
  end

endmodule
